// File: rtl/phy_rx_lane_deser_if.sv
// Lane-side signal bundle for the per-lane RX deserializer.
// The master drives the serial bit; the slave (the deserializer) returns the aligned bytes.
interface phy_rx_lane_deser_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       byte_strobe;
    logic       valid_out;
    logic       active_out;

    modport master (
        output data_in,
        input  data_out,
        input  byte_strobe,
        input  valid_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output byte_strobe,
        output valid_out,
        output active_out
    );
endinterface

// File: rtl/phy_rx_lane_deser.sv
// Per-lane RX deserializer: bit-slip search for COM, lock after LOCK_COUNT aligned COMs, byte output.
// Optional build macro RX_GAP_CHECK_EN drops lock after MAX_GAP consecutive non-COM bytes.
module phy_rx_lane_deser #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         LOCK_COUNT = 4
`ifdef RX_GAP_CHECK_EN
    , parameter int       MAX_GAP    = 64
`endif
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    phy_rx_lane_deser_if.slave   lane
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);
`ifdef RX_GAP_CHECK_EN
    localparam logic [8:0] MAX_GAP_L  = 9'(MAX_GAP);
`endif

    state_t      state_r;
    logic [6:0]  sr_r;
    logic [2:0]  bit_cnt_r;
    logic [3:0]  com_cnt_r;
`ifdef RX_GAP_CHECK_EN
    logic [7:0]  gap_cnt_r;
    logic [8:0]  gap_cnt_next_s;
`endif
    logic [7:0]  data_out_r;
    logic        strobe_r;
    logic        valid_r;
    logic        active_r;

    logic [7:0]  nb_s;
    logic        boundary_s;
    logic        is_com_s;
    logic [4:0]  com_cnt_next_s;

    // Candidate byte includes the bit being sampled this cycle.
    assign nb_s           = {sr_r, lane.data_in};
    assign is_com_s       = (nb_s == COM);
    assign boundary_s     = (bit_cnt_r == 3'd7);
    assign com_cnt_next_s = {1'b0, com_cnt_r} + 5'd1;
`ifdef RX_GAP_CHECK_EN
    assign gap_cnt_next_s = {1'b0, gap_cnt_r} + 9'd1;
`endif

    assign lane.data_out    = data_out_r;
    assign lane.byte_strobe = strobe_r;
    assign lane.valid_out   = valid_r;
    assign lane.active_out  = active_r;

    // Alignment FSM, shift register, counters and registered byte outputs.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_r    <= SEARCH;
            sr_r       <= 7'd0;
            bit_cnt_r  <= 3'd0;
            com_cnt_r  <= 4'd0;
`ifdef RX_GAP_CHECK_EN
            gap_cnt_r  <= 8'd0;
`endif
            data_out_r <= 8'h00;
            strobe_r   <= 1'b0;
            valid_r    <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            sr_r     <= nb_s[6:0];
            strobe_r <= 1'b0;
            case (state_r)
                SEARCH: begin
                    if (is_com_s) begin
                        bit_cnt_r <= 3'd0;
                        com_cnt_r <= 4'd1;
                        if (LOCK_CNT_L == 4'd1) begin
                            state_r  <= ALIGNED;
                            active_r <= 1'b1;
                        end else begin
                            state_r  <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        if (is_com_s) begin
                            if (com_cnt_r != 4'hF) begin
                                com_cnt_r <= com_cnt_next_s[3:0];
                            end
                            if (com_cnt_next_s >= {1'b0, LOCK_CNT_L}) begin
                                state_r  <= ALIGNED;
                                active_r <= 1'b1;
                            end
                        end else begin
                            com_cnt_r <= 4'd0;
                            state_r   <= SEARCH;
                        end
                    end
                end
                ALIGNED: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (boundary_s) begin
                        data_out_r <= nb_s;
                        strobe_r   <= 1'b1;
                        valid_r    <= !is_com_s;
`ifdef RX_GAP_CHECK_EN
                        // The byte that hits the gap limit is still emitted before lock drops.
                        if (is_com_s) begin
                            gap_cnt_r <= 8'd0;
                        end else if (gap_cnt_next_s >= MAX_GAP_L) begin
                            gap_cnt_r <= 8'd0;
                            com_cnt_r <= 4'd0;
                            state_r   <= SEARCH;
                            active_r  <= 1'b0;
                        end else begin
                            gap_cnt_r <= gap_cnt_next_s[7:0];
                        end
`endif
                    end
                end
                default: begin
                    state_r   <= SEARCH;
                    com_cnt_r <= 4'd0;
                    active_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
